// File: rtl/stream_capture.sv
// Captures LANES x DW-bit vectors from a valid/ready stream into a linear RAM,
// with an optional circular mode and a registered single-lane read port.
module stream_capture #(
    parameter int LANES = 64,
    parameter int DW    = 32,
    parameter int AW    = 11,
    parameter int LW    = 6
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                CEB,
    input  logic                start,
    input  logic                wrap_en,
    input  logic                in_valid,
    input  logic [LANES*DW-1:0] in_data,
    output logic                in_ready,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    input  logic [LW-1:0]       rd_lane,
    output logic [DW-1:0]       rd_data,
    output logic                rd_valid,
    output logic [AW:0]         wr_count,
    output logic                busy,
    output logic                full,
    output logic                overflow
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_nextState;
    logic [AW-1:0]                r_wrPtr;
    logic [AW:0]                  r_wrCount;
    logic                         r_overflow;
    logic [DW-1:0]                r_rdData;
    logic                         r_rdValid;
    logic [LANES-1:0][DW-1:0]     r_mem [DEPTH];

    logic                         w_start;
    logic                         w_accept;
    logic                         w_lastAddr;
    logic [DW-1:0]                w_rdLane;

    assign w_start    = start & ~CEB;
    assign in_ready   = (r_state == CAPTURE) & ~CEB & ~start;
    assign w_accept   = in_valid & in_ready;
    assign w_lastAddr = &r_wrPtr;

    // Lanes beyond LANES exist only when LW over-provisions the select.
    always_comb begin
        w_rdLane = '0;
        if (int'(rd_lane) < LANES) begin
            w_rdLane = r_mem[rd_addr][rd_lane];
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = IDLE;
            CAPTURE: begin
                if (w_accept && w_lastAddr && !wrap_en) begin
                    w_nextState = FULL;
                end
            end
            FULL:    w_nextState = FULL;
            default: w_nextState = IDLE;
        endcase
        if (w_start) begin
            w_nextState = CAPTURE;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wrPtr    <= '0;
            r_wrCount  <= '0;
            r_overflow <= 1'b0;
            r_rdData   <= '0;
            r_rdValid  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_start) begin
                r_wrPtr    <= '0;
                r_wrCount  <= '0;
                r_overflow <= 1'b0;
            end else if (w_accept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                if (r_wrCount != COUNT_MAX) begin
                    r_wrCount <= r_wrCount + 1'b1;
                end
                if (wrap_en && (r_wrCount == COUNT_MAX)) begin
                    r_overflow <= 1'b1;
                end
            end
            // Reading the array here before the write lands gives read-before-write.
            if (rd_en && !CEB) begin
                r_rdData  <= w_rdLane;
                r_rdValid <= 1'b1;
            end else begin
                r_rdValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    assign rd_data  = r_rdData;
    assign rd_valid = r_rdValid;
    assign wr_count = r_wrCount;
    assign overflow = r_overflow;
    assign busy     = (r_state == CAPTURE);
    assign full     = (r_state == FULL);

endmodule

// File: tb/tb_stream_capture.sv
// Bench for stream_capture: directed scenarios plus a randomized phase, all
// checked every cycle against a transaction-level model of the capture buffer.
module tb_stream_capture;

    localparam int LANES = 64;
    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int LW    = 6;
    localparam int DEPTH = 2 ** AW;
    localparam int VW    = LANES * DW;

    logic            CLK = 1'b0;
    logic            rst;
    logic            CEB;
    logic            start;
    logic            wrap_en;
    logic            in_valid;
    logic [VW-1:0]   in_data;
    logic            in_ready;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [LW-1:0]   rd_lane;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic [AW:0]     wr_count;
    logic            busy;
    logic            full;
    logic            overflow;

    always #5 CLK = ~CLK;

    stream_capture #(.LANES(LANES), .DW(DW), .AW(AW), .LW(LW)) dut (
        .CLK(CLK), .rst(rst), .CEB(CEB), .start(start), .wrap_en(wrap_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_lane(rd_lane),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_count(wr_count),
        .busy(busy), .full(full), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    // Model: what the buffer should hold and report, from the block's rules.
    bit              mCapturing;
    bit              mFull;
    bit              mOverflow;
    bit              mRdValid;
    bit              mRdKnown;
    int              mPtr;
    int              mCount;
    logic [DW-1:0]   mRdData;
    logic [VW-1:0]   mMem [int];

    function automatic logic [VW-1:0] patVec(input int n);
        logic [VW-1:0] v;
        for (int k = 0; k < LANES; k++) begin
            v[k*DW +: DW] = {16'(n), 16'(k)};
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] randVec();
        logic [VW-1:0] v;
        for (int k = 0; k < LANES; k++) begin
            v[k*DW +: DW] = $urandom;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mCapturing = 0;
        mFull      = 0;
        mOverflow  = 0;
        mPtr       = 0;
        mCount     = 0;
        mRdValid   = 0;
        mRdData    = '0;
        mRdKnown   = 1;
    endtask

    task automatic modelClock();
        logic [VW-1:0] word;
        if (!rst) begin
            modelReset();
            return;
        end
        if (CEB) begin
            mRdValid = 0;
            return;
        end
        if (rd_en) begin
            mRdValid = 1;
            if (int'(rd_lane) >= LANES) begin
                mRdData  = '0;
                mRdKnown = 1;
            end else if (mMem.exists(int'(rd_addr))) begin
                word     = mMem[int'(rd_addr)];
                mRdData  = word[int'(rd_lane)*DW +: DW];
                mRdKnown = 1;
            end else begin
                mRdKnown = 0;
            end
        end else begin
            mRdValid = 0;
        end
        if (start) begin
            mCapturing = 1;
            mFull      = 0;
            mPtr       = 0;
            mCount     = 0;
            mOverflow  = 0;
        end else if (mCapturing && in_valid) begin
            if (wrap_en && mCount == DEPTH) mOverflow = 1;
            mMem[mPtr] = in_data;
            if (mPtr == DEPTH - 1 && !wrap_en) begin
                mCapturing = 0;
                mFull      = 1;
            end
            mPtr   = (mPtr + 1) % DEPTH;
            mCount = (mCount + 1 > DEPTH) ? DEPTH : mCount + 1;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        modelClock();
        #1;
    endtask

    task automatic applyStimulus(input bit st, input bit vld, input logic [VW-1:0] data,
                                 input bit rEn, input int rAddr, input int rLane);
        start    = st;
        in_valid = vld;
        in_data  = data;
        rd_en    = rEn;
        rd_addr  = AW'(rAddr);
        rd_lane  = LW'(rLane);
        tick();
    endtask

    task automatic idle();
        applyStimulus(0, 0, '0, 0, 0, 0);
    endtask

    task automatic readLane(input int addr, input int lane, input string name,
                            input logic [31:0] expected);
        applyStimulus(0, 0, '0, 1, addr, lane);
        checkOutput({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
        checkOutput(name, rd_data, expected);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (checkEn) begin
                checkOutput("in_ready", {31'd0, in_ready},
                            {31'd0, mCapturing && !CEB && !start && rst});
                checkOutput("busy", {31'd0, busy}, {31'd0, mCapturing});
                checkOutput("full", {31'd0, full}, {31'd0, mFull});
                checkOutput("wr_count", 32'(wr_count), 32'(mCount));
                checkOutput("overflow", {31'd0, overflow}, {31'd0, mOverflow});
                checkOutput("rd_valid", {31'd0, rd_valid}, {31'd0, mRdValid});
                if (mRdValid && mRdKnown) begin
                    checkOutput("rd_data", rd_data, mRdData);
                end
            end
        end
    end

    initial begin
        int savedCount;
        rst = 0; CEB = 0; start = 0; wrap_en = 0; in_valid = 0;
        in_data = '0; rd_en = 0; rd_addr = '0; rd_lane = '0;
        modelReset();
        repeat (3) tick();
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_full", {31'd0, full}, 32'd0);
        checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
        checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        checkOutput("rst_rd_data", rd_data, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1;
        checkEn = 1;
        idle();

        $display("[TB] basic capture and read");
        applyStimulus(1, 0, '0, 0, 0, 0);
        for (int n = 0; n < 4; n++) applyStimulus(0, 1, patVec(n), 0, 0, 0);
        idle();
        checkOutput("t1_wr_count", 32'(wr_count), 32'd4);
        checkOutput("t1_busy", {31'd0, busy}, 32'd1);
        readLane(2, 5, "t1_rd", 32'h0002_0005);

        $display("[TB] fill without wrap");
        wrap_en = 0;
        applyStimulus(1, 0, '0, 0, 0, 0);
        for (int n = 0; n < DEPTH; n++) applyStimulus(0, 1, patVec(n), 0, 0, 0);
        checkOutput("t2_full", {31'd0, full}, 32'd1);
        checkOutput("t2_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("t2_wr_count", 32'(wr_count), 32'd2048);
        checkOutput("t2_overflow", {31'd0, overflow}, 32'd0);
        applyStimulus(0, 1, patVec(16'h1234), 0, 0, 0);
        checkOutput("t2_extra_wr_count", 32'(wr_count), 32'd2048);
        readLane(0, 0, "t2_rd_addr0", 32'h0000_0000);

        $display("[TB] circular capture");
        wrap_en = 1;
        applyStimulus(1, 0, '0, 0, 0, 0);
        for (int n = 0; n < DEPTH + 2; n++) applyStimulus(0, 1, patVec(n), 0, 0, 0);
        idle();
        checkOutput("t3_busy", {31'd0, busy}, 32'd1);
        checkOutput("t3_overflow", {31'd0, overflow}, 32'd1);
        checkOutput("t3_wr_count", 32'(wr_count), 32'd2048);
        readLane(0, 0, "t3_rd_addr0", 32'h0800_0000);
        readLane(2, 3, "t3_rd_addr2", 32'h0002_0003);
        readLane(1, 0, "t3_rd_addr1", 32'h0801_0000);

        $display("[TB] start drops concurrent beat");
        applyStimulus(1, 1, patVec(16'hAAAA), 0, 0, 0);
        applyStimulus(0, 1, patVec(16'h0055), 0, 0, 0);
        idle();
        checkOutput("t4_wr_count", 32'(wr_count), 32'd1);
        checkOutput("t4_overflow", {31'd0, overflow}, 32'd0);
        readLane(0, 1, "t4_rd_addr0", 32'h0055_0001);
        readLane(2, 0, "t4_rd_addr2", 32'h0002_0000);

        $display("[TB] read-before-write collision");
        for (int n = 1; n < 7; n++) applyStimulus(0, 1, patVec(n), 0, 0, 0);
        applyStimulus(0, 1, patVec(16'h0777), 1, 7, 2);
        checkOutput("t5_old", rd_data, 32'h0007_0002);
        readLane(7, 2, "t5_new", 32'h0777_0002);

        $display("[TB] block disable and async reset");
        savedCount = int'(wr_count);
        CEB = 1;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 1, randVec(), 1, 3, 4);
            checkOutput("t6_ceb_rd_valid", {31'd0, rd_valid}, 32'd0);
            checkOutput("t6_ceb_wr_count", 32'(wr_count), 32'(savedCount));
        end
        CEB = 0;
        applyStimulus(0, 1, randVec(), 0, 0, 0);
        applyStimulus(0, 1, randVec(), 0, 0, 0);
        checkOutput("t6_resume_wr_count", 32'(wr_count), 32'(savedCount + 2));
        #2;
        rst = 0;
        modelReset();
        #1;
        checkOutput("t6_rst_wr_count", 32'(wr_count), 32'd0);
        checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
        applyStimulus(0, 1, randVec(), 0, 0, 0);
        rst = 1;
        idle();
        checkOutput("t6_after_rst_wr_count", 32'(wr_count), 32'd0);

        $display("[TB] randomized traffic");
        applyStimulus(1, 0, '0, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) wrap_en = $urandom_range(0, 1) == 1;
            CEB = ($urandom_range(0, 9) == 0);
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
                          randVec(), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 31), $urandom_range(0, LANES - 1));
        end
        CEB = 0;
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
